// File: rtl/riscv_defs.sv
// Shared RV32I definitions for the memory stage: widths, funct3 encodings
// of loads/stores and the load/store unit state encoding.
package riscv_defs;

  localparam int NB_ADDR = 32;
  localparam int NB_WORD = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } lsu_funct3_t;

  // Stores share their encodings with the signed loads.
  localparam lsu_funct3_t SB = LB;
  localparam lsu_funct3_t SH = LH;
  localparam lsu_funct3_t SW = LW;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DATA  = 2'd2,
    WR_ISSUE = 2'd3
  } lsu_state_t;

  // True when funct3 names a real RV32I load (we=0) or store (we=1).
  function automatic logic lsu_funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (we) begin
      ok = (f3 == SB) || (f3 == SH) || (f3 == SW);
    end else begin
      ok = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte/halfword lane handling: load extraction with sign/zero extension and
// the merge of store data into a read word for sub-word stores.
module lsu_lane_align
  import riscv_defs::*;
#(
  parameter int NB_WORD = riscv_defs::NB_WORD
) (
  input  logic [2:0]         funct3_i,
  input  logic [1:0]         off_i,
  input  logic [NB_WORD-1:0] rd_word_i,
  input  logic [NB_WORD-1:0] wdata_i,
  output logic [NB_WORD-1:0] load_data_o,
  output logic [NB_WORD-1:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane and extend it to a full word for loads.
  always_comb begin
    byte_sel    = rd_word_i[{off_i, 3'b000} +: 8];
    half_sel    = rd_word_i[{off_i[1], 4'b0000} +: 16];
    load_data_o = '0;
    case (lsu_funct3_t'(funct3_i))
      LB:      load_data_o = {{(NB_WORD-8){byte_sel[7]}}, byte_sel};
      LH:      load_data_o = {{(NB_WORD-16){half_sel[15]}}, half_sel};
      LW:      load_data_o = rd_word_i;
      LBU:     load_data_o = {{(NB_WORD-8){1'b0}}, byte_sel};
      LHU:     load_data_o = {{(NB_WORD-16){1'b0}}, half_sel};
      default: load_data_o = '0;
    endcase
  end

  // Overlay the low store bits onto the addressed lane of the read word.
  always_comb begin
    merged_o = rd_word_i;
    case (funct3_i[1:0])
      2'b00:   merged_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
      2'b01:   merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request at a time onto a word-wide data
// memory without byte enables; sub-word stores use read-modify-write.
module load_store_unit
  import riscv_defs::*;
#(
  parameter int NB_ADDR = riscv_defs::NB_ADDR,
  parameter int NB_WORD = riscv_defs::NB_WORD
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_req_valid,
  input  logic               i_req_we,
  input  logic [2:0]         i_req_funct3,
  input  logic [NB_ADDR-1:0] i_req_addr,
  input  logic [NB_WORD-1:0] i_req_wdata,
  output logic               o_busy,
  output logic               o_rsp_valid,
  output logic [NB_WORD-1:0] o_rsp_rdata,
  output logic               o_fault,
  output logic [NB_ADDR-1:0] o_dmem_address,
  output logic [NB_WORD-1:0] o_dmem_wr_data,
  output logic               o_dmem_wr_enable,
  input  logic [NB_WORD-1:0] i_dmem_rd_data
);

  lsu_state_t         state_q, state_d;
  logic               fault_q, fault_d;
  logic               req_fault;
  logic               accept_ok;
  logic               we_q;
  logic [2:0]         funct3_q;
  logic [1:0]         off_q;
  logic [NB_WORD-1:0] wdata_q;
  logic [NB_ADDR-1:0] addr_q;
  logic [NB_WORD-1:0] wr_data_q;
  logic [NB_WORD-1:0] load_data;
  logic [NB_WORD-1:0] merged;

  // Illegal funct3 or an access not aligned to its own size faults.
  always_comb begin
    req_fault = !lsu_funct3_legal(i_req_we, i_req_funct3);
    if ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) req_fault = 1'b1;
    if ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00)) req_fault = 1'b1;
  end

  assign accept_ok = (state_q == IDLE) && i_req_valid && !req_fault;

  // Next-state: loads and sub-word stores read first, SW writes directly.
  always_comb begin
    state_d = state_q;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          if (req_fault)                          fault_d = 1'b1;
          else if (i_req_we && (i_req_funct3 == SW)) state_d = WR_ISSUE;
          else                                    state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_DATA;
      RD_DATA:  state_d = we_q ? WR_ISSUE : IDLE;
      WR_ISSUE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register and fault pulse; reset drops any pending write.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Request latch, held memory address and write-data register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      we_q      <= 1'b0;
      funct3_q  <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else if (accept_ok) begin
      we_q     <= i_req_we;
      funct3_q <= i_req_funct3;
      off_q    <= i_req_addr[1:0];
      wdata_q  <= i_req_wdata;
      addr_q   <= {i_req_addr[NB_ADDR-1:2], 2'b00};
      if (i_req_we && (i_req_funct3 == SW)) wr_data_q <= i_req_wdata;
    end else if ((state_q == RD_DATA) && we_q) begin
      wr_data_q <= merged;
    end
  end

  lsu_lane_align #(
    .NB_WORD(NB_WORD)
  ) u_lane_align (
    .funct3_i   (funct3_q),
    .off_i      (off_q),
    .rd_word_i  (i_dmem_rd_data),
    .wdata_i    (wdata_q),
    .load_data_o(load_data),
    .merged_o   (merged)
  );

  assign o_busy           = (state_q != IDLE);
  assign o_fault          = fault_q;
  assign o_rsp_valid      = fault_q || ((state_q == RD_DATA) && !we_q) || (state_q == WR_ISSUE);
  assign o_rsp_rdata      = ((state_q == RD_DATA) && !we_q) ? load_data : '0;
  assign o_dmem_address   = addr_q;
  assign o_dmem_wr_data   = wr_data_q;
  assign o_dmem_wr_enable = (state_q == WR_ISSUE);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table vectors, hand sequences, random traffic
// against a byte-level reference model and a bench-side data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy, rsp_valid, fault, wen;
  logic [31:0] rdata, dmem_addr, dmem_wdata, dmem_rd;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_data;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic        flt;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [14];

  always #5 clk = ~clk;

  load_store_unit dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_req_valid     (req_valid),
    .i_req_we        (req_we),
    .i_req_funct3    (req_f3),
    .i_req_addr      (req_addr),
    .i_req_wdata     (req_wdata),
    .o_busy          (busy),
    .o_rsp_valid     (rsp_valid),
    .o_rsp_rdata     (rdata),
    .o_fault         (fault),
    .o_dmem_address  (dmem_addr),
    .o_dmem_wr_data  (dmem_wdata),
    .o_dmem_wr_enable(wen),
    .i_dmem_rd_data  (dmem_rd)
  );

  // Word memory: registered read, write on strobe, plus a backdoor port.
  always @(posedge clk) begin
    dmem_rd <= mem[dmem_addr[7:2]];
    if (wen) mem[dmem_addr[7:2]] <= dmem_wdata;
    if (bd_we) mem[bd_idx] <= bd_data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = addr[7:2]; bd_data = data;
    ref_mem[addr[7:2]] = data;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Reference model: rules expressed with shifts and masks on whole words.
  function automatic logic model_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic bad;
    if (we) bad = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    bad = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) bad = 1'b1;
    if (f3 == 3'd2 && (a % 4 != 0)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * (a % 4));
    case (f3)
      3'd0: return (s & 32'h80) != 0 ? ((s & 32'hFF) | 32'hFFFFFF00) : (s & 32'hFF);
      3'd1: return (s & 32'h8000) != 0 ? ((s & 32'hFFFF) | 32'hFFFF0000) : (s & 32'hFFFF);
      3'd4: return s & 32'hFF;
      3'd5: return s & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFFFFFF;
    sh = 8 * (a % 4);
    return (w & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  // Issue one request and check a five-cycle window of outputs.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic exp_flt, input logic [31:0] exp,
                         input string tag);
    logic [4:0]  busy_s, rsp_s, flt_s, wen_s, addr_ok;
    logic [4:0]  e_busy, e_rsp, e_flt, e_wen;
    logic [31:0] rdata_at, wdata_at, rdata_other, addr_before, exp_addr;
    @(negedge clk);
    addr_before = dmem_addr;
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
    exp_addr = exp_flt ? addr_before : {addr[31:2], 2'b00};
    busy_s = '0; rsp_s = '0; flt_s = '0; wen_s = '0; addr_ok = '0;
    rdata_at = '0; wdata_at = '0; rdata_other = '0;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      busy_s[c] = busy; rsp_s[c] = rsp_valid; flt_s[c] = fault; wen_s[c] = wen;
      if (rsp_valid) rdata_at = rdata; else rdata_other = rdata_other | rdata;
      if (wen) wdata_at = dmem_wdata;
      addr_ok[c] = (dmem_addr == exp_addr);
    end
    e_flt = '0; e_wen = '0;
    if (exp_flt) begin
      e_busy = 5'b00000; e_rsp = 5'b00001; e_flt = 5'b00001;
    end else if (!we) begin
      e_busy = 5'b00011; e_rsp = 5'b00010;
    end else if (f3 == 3'd2) begin
      e_busy = 5'b00001; e_rsp = 5'b00001; e_wen = 5'b00001;
    end else begin
      e_busy = 5'b00111; e_rsp = 5'b00100; e_wen = 5'b00100;
    end
    chk({tag, " busy"}, 32'(busy_s), 32'(e_busy));
    chk({tag, " rsp_valid"}, 32'(rsp_s), 32'(e_rsp));
    chk({tag, " fault"}, 32'(flt_s), 32'(e_flt));
    chk({tag, " wr_enable"}, 32'(wen_s), 32'(e_wen));
    chk({tag, " address"}, 32'(addr_ok), 32'h1F);
    chk({tag, " rdata idle"}, rdata_other, 32'h0);
    if (!exp_flt && !we) chk({tag, " rdata"}, rdata_at, exp);
    else                 chk({tag, " rdata"}, rdata_at, 32'h0);
    if (!exp_flt && we) begin
      chk({tag, " wr_data"}, wdata_at, exp);
      ref_mem[addr[7:2]] = exp;
    end
  endtask

  initial begin
    logic        we, flt;
    logic [2:0]  f3;
    logic [31:0] a, wd, ex;
    logic [5:0]  busy_s, rsp_s, wen_s;
    logic [31:0] rd_seen;
    logic        wen_any;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_f3 = '0;
    req_addr = '0; req_wdata = '0; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset busy/rsp/fault/wen", {28'h0, busy, rsp_valid, fault, wen}, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset address", dmem_addr, 32'h0);
    chk("reset wr_data", dmem_wdata, 32'h0);

    for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);

    //         we    f3      addr        wdata         init          flt   exp
    tbl[0]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h8899AABB, 1'b0, 32'hFFFFFF88};
    tbl[1]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h8899AABB, 1'b0, 32'h00000088};
    tbl[2]  = '{1'b0, 3'b000, 32'h100, 32'h0,        32'h8899AABB, 1'b0, 32'hFFFFFFBB};
    tbl[3]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h8899AABB, 1'b0, 32'hFFFF8899};
    tbl[4]  = '{1'b0, 3'b101, 32'h100, 32'h0,        32'h8899AABB, 1'b0, 32'h0000AABB};
    tbl[5]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h8899AABB, 1'b0, 32'h8899AABB};
    tbl[6]  = '{1'b0, 3'b100, 32'h101, 32'h0,        32'h8899AABB, 1'b0, 32'h000000AA};
    tbl[7]  = '{1'b1, 3'b000, 32'h101, 32'h12345677, 32'h8899AABB, 1'b0, 32'h889977BB};
    tbl[8]  = '{1'b1, 3'b001, 32'h102, 32'h0000CAFE, 32'h8899AABB, 1'b0, 32'hCAFEAABB};
    tbl[9]  = '{1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h00000000, 1'b0, 32'hDEADBEEF};
    tbl[10] = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h8899AABB, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 3'b001, 32'h103, 32'h0000CAFE, 32'h8899AABB, 1'b1, 32'h0};
    tbl[12] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h8899AABB, 1'b1, 32'h0};
    tbl[13] = '{1'b1, 3'b100, 32'h100, 32'h000000FF, 32'h8899AABB, 1'b1, 32'h0};

    for (int i = 0; i < 14; i++) begin
      preload(tbl[i].addr, tbl[i].init);
      run_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].flt, tbl[i].exp,
              $sformatf("tbl%0d", i));
    end

    // Second request held high while busy must wait for IDLE.
    preload(32'h108, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b010; req_addr = 32'h108; req_wdata = 32'h11223344;
    busy_s = '0; rsp_s = '0; wen_s = '0; rd_seen = '0;
    @(posedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin req_we = 1'b0; req_wdata = 32'h0; end
      if (c == 2) req_valid = 1'b0;
      busy_s[c] = busy; rsp_s[c] = rsp_valid; wen_s[c] = wen;
      if (c == 3) rd_seen = rdata;
    end
    ref_mem[2] = 32'h11223344;
    chk("held busy", 32'(busy_s), 32'h0D);
    chk("held rsp_valid", 32'(rsp_s), 32'h09);
    chk("held wr_enable", 32'(wen_s), 32'h01);
    chk("held load data", rd_seen, 32'h11223344);

    // Reset during the read phase of an SB drops the pending write.
    preload(32'h100, 32'h8899AABB);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b000; req_addr = 32'h101; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst-seq busy before reset", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst-seq busy/rsp/fault/wen", {28'h0, busy, rsp_valid, fault, wen}, 32'h0);
    chk("rst-seq rdata", rdata, 32'h0);
    chk("rst-seq address", dmem_addr, 32'h0);
    chk("rst-seq wr_data", dmem_wdata, 32'h0);
    wen_any = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      wen_any = wen_any | wen;
    end
    chk("rst-seq no write", 32'(wen_any), 32'h0);
    chk("rst-seq memory intact", mem[0], 32'h8899AABB);
    run_req(1'b0, 3'b100, 32'h100, 32'h0, 1'b0, 32'h000000BB, "post-reset LBU");

    // Random traffic against the reference model.
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else begin
          f3 = 3'($urandom_range(0, 4));
          if (f3 == 3'd3) f3 = 3'd5;
        end
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      a  = 32'h100 + 32'($urandom_range(0, 63));
      wd = $urandom;
      flt = model_fault(we, f3, a);
      if (flt)     ex = 32'h0;
      else if (we) ex = model_store(f3, a, ref_mem[a[7:2]], wd);
      else         ex = model_load(f3, a, ref_mem[a[7:2]]);
      run_req(we, f3, a, wd, flt, ex, $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    for (int i = 0; i < 16; i++) chk($sformatf("mem word %0d", i), mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
